// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller with 100Hz prescaler and BCD MM:SS.CC time base.
// Optional lap capture is enabled by defining SW_LAP_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int CNT_W    = 19
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    input  logic       BTN_CLR,
    output logic       EN100HZ,
    output logic       RUNNING,
    output logic       FROZEN,
    output logic [7:0] DISP_MIN,
    output logic [7:0] DISP_SEC,
    output logic [7:0] DISP_CS,
    output logic       OVF
);

`ifdef SW_LAP_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP_RUN, S_LAP_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic             prev_ss_q, prev_lap_q, prev_clr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       min_q, min_d, sec_q, sec_d, cs_q, cs_d;
    logic             ovf_q, ovf_d;
    logic             ev_ss, ev_lap, ev_clr;
    logic             clr_acc, running, tick;
    logic [8:0]       cs_inc, sec_inc, min_inc;

    // Returns {carry, next}; wraps to 00 after reaching lim.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return 9'h100;
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // One event per cycle: a higher-priority edge swallows lower ones even if it is ignored.
    always_comb begin
        ev_clr = BTN_CLR & ~prev_clr_q;
        ev_ss  = BTN_SS & ~prev_ss_q & ~ev_clr;
        ev_lap = BTN_LAP & ~prev_lap_q & ~ev_clr & ~(BTN_SS & ~prev_ss_q);
    end

    always_comb begin
        state_d = state_q;
        clr_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_ss)
                    state_d = S_RUN;
                else if (ev_clr)
                    clr_acc = 1'b1;
            end
            S_RUN: begin
                if (ev_ss)
                    state_d = S_PAUSE;
`ifdef SW_LAP_EN
                else if (ev_lap)
                    state_d = S_LAP_RUN;
`endif
            end
            S_PAUSE: begin
                if (ev_ss) begin
                    state_d = S_RUN;
                end else if (ev_clr) begin
                    state_d = S_IDLE;
                    clr_acc = 1'b1;
                end
            end
`ifdef SW_LAP_EN
            S_LAP_RUN: begin
                if (ev_lap)
                    state_d = S_RUN;
                else if (ev_ss)
                    state_d = S_LAP_PAUSE;
            end
            S_LAP_PAUSE: begin
                if (ev_lap) begin
                    state_d = S_PAUSE;
                end else if (ev_ss) begin
                    state_d = S_LAP_RUN;
                end else if (ev_clr) begin
                    state_d = S_IDLE;
                    clr_acc = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SW_LAP_EN
    assign running = (state_q == S_RUN) || (state_q == S_LAP_RUN);
`else
    assign running = (state_q == S_RUN);
`endif
    assign tick = running && (cnt_q == TICK_MAX);

    always_comb begin
        cs_inc  = bcd_inc(cs_q, 8'h99);
        sec_inc = bcd_inc(sec_q, 8'h59);
        min_inc = bcd_inc(min_q, 8'h59);
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        if (clr_acc) begin
            cnt_d = '0;
            cs_d  = 8'h00;
            sec_d = 8'h00;
            min_d = 8'h00;
            ovf_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            cs_d  = cs_inc[7:0];
            if (cs_inc[8]) begin
                sec_d = sec_inc[7:0];
                if (sec_inc[8]) begin
                    min_d = min_inc[7:0];
                    if (min_inc[8])
                        ovf_d = 1'b1;
                end
            end
        end else if (running) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // History regs reset high so a button held through reset needs a fresh press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            prev_ss_q  <= 1'b1;
            prev_lap_q <= 1'b1;
            prev_clr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_ss_q  <= BTN_SS;
            prev_lap_q <= BTN_LAP;
            prev_clr_q <= BTN_CLR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            cs_q  <= 8'h00;
            sec_q <= 8'h00;
            min_q <= 8'h00;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cs_q  <= cs_d;
            sec_q <= sec_d;
            min_q <= min_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef SW_LAP_EN
    logic [7:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d, lap_cs_q, lap_cs_d;
    logic       lap_load;

    // Capture the pre-tick live value; a coincident tick shows on the live counters only.
    always_comb begin
        lap_load  = (state_q == S_RUN) && (state_d == S_LAP_RUN);
        lap_min_d = lap_min_q;
        lap_sec_d = lap_sec_q;
        lap_cs_d  = lap_cs_q;
        if (clr_acc) begin
            lap_min_d = 8'h00;
            lap_sec_d = 8'h00;
            lap_cs_d  = 8'h00;
        end else if (lap_load) begin
            lap_min_d = min_q;
            lap_sec_d = sec_q;
            lap_cs_d  = cs_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lap_min_q <= 8'h00;
            lap_sec_q <= 8'h00;
            lap_cs_q  <= 8'h00;
        end else begin
            lap_min_q <= lap_min_d;
            lap_sec_q <= lap_sec_d;
            lap_cs_q  <= lap_cs_d;
        end
    end

    assign FROZEN   = (state_q == S_LAP_RUN) || (state_q == S_LAP_PAUSE);
    assign DISP_MIN = FROZEN ? lap_min_q : min_q;
    assign DISP_SEC = FROZEN ? lap_sec_q : sec_q;
    assign DISP_CS  = FROZEN ? lap_cs_q  : cs_q;
`else
    logic lap_unused;
    assign lap_unused = ev_lap;
    assign FROZEN     = 1'b0;
    assign DISP_MIN   = min_q;
    assign DISP_SEC   = sec_q;
    assign DISP_CS    = cs_q;
`endif

    assign EN100HZ = tick;
    assign RUNNING = running;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4; lap checks follow SW_LAP_EN.
module tb_stopwatch_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_SS = 1'b0, BTN_LAP = 1'b0, BTN_CLR = 1'b0;
    logic       EN100HZ, RUNNING, FROZEN, OVF;
    logic [7:0] DISP_MIN, DISP_SEC, DISP_CS;

    stopwatch_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP), .BTN_CLR(BTN_CLR),
        .EN100HZ(EN100HZ), .RUNNING(RUNNING), .FROZEN(FROZEN),
        .DISP_MIN(DISP_MIN), .DISP_SEC(DISP_SEC), .DISP_CS(DISP_CS), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       run;
        logic       frz;
        logic       en;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [7:0] cs;
        logic       ovf;
    } outs_t;

    typedef struct packed {
        logic  ss;
        logic  lap;
        logic  clr;
        outs_t exp;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    outs_t exp_q[$];
    vec_t  tbl[24];
    outs_t zero;

    function automatic outs_t mk(input logic run, input logic frz, input logic en,
                                 input logic [7:0] mn, input logic [7:0] sc,
                                 input logic [7:0] cs, input logic ovf);
        return {run, frz, en, mn, sc, cs, ovf};
    endfunction

    function automatic outs_t cur();
        return {RUNNING, FROZEN, EN100HZ, DISP_MIN, DISP_SEC, DISP_CS, OVF};
    endfunction

    task automatic compare(input string nm, input outs_t e);
        outs_t a;
        a = cur();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got run=%b frz=%b en=%b %h:%h.%h ovf=%b, want run=%b frz=%b en=%b %h:%h.%h ovf=%b",
                     nm, a.run, a.frz, a.en, a.mn, a.sc, a.cs, a.ovf,
                     e.run, e.frz, e.en, e.mn, e.sc, e.cs, e.ovf);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic drive(input logic ss, input logic lap, input logic clr);
        @(negedge CLK);
        BTN_SS  = ss;
        BTN_LAP = lap;
        BTN_CLR = clr;
    endtask

    task automatic step(input logic ss, input logic lap, input logic clr);
        drive(ss, lap, clr);
        @(posedge CLK);
        #1;
    endtask

    task automatic stepx(input string nm, input logic ss, input logic lap, input logic clr,
                         input outs_t e);
        drive(ss, lap, clr);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        compare(nm, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int en_bad;
        bit seen;

        zero = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        tbl[0]  = {3'b000, zero};
        tbl[1]  = {3'b100, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0)};
        tbl[2]  = {3'b100, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0)};
        tbl[3]  = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0)};
        tbl[4]  = {3'b000, mk(1, 0, 1, 8'h00, 8'h00, 8'h00, 0)};
        tbl[5]  = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h01, 0)};
        tbl[6]  = {3'b001, mk(1, 0, 0, 8'h00, 8'h00, 8'h01, 0)};
        tbl[7]  = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h01, 0)};
        tbl[8]  = {3'b000, mk(1, 0, 1, 8'h00, 8'h00, 8'h01, 0)};
        tbl[9]  = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h02, 0)};
        tbl[10] = {3'b101, mk(1, 0, 0, 8'h00, 8'h00, 8'h02, 0)};
        tbl[11] = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h02, 0)};
        tbl[12] = {3'b100, mk(0, 0, 0, 8'h00, 8'h00, 8'h02, 0)};
        tbl[13] = {3'b000, mk(0, 0, 0, 8'h00, 8'h00, 8'h02, 0)};
        tbl[14] = {3'b100, mk(1, 0, 1, 8'h00, 8'h00, 8'h02, 0)};
        tbl[15] = {3'b000, mk(1, 0, 0, 8'h00, 8'h00, 8'h03, 0)};
        tbl[16] = {3'b100, mk(0, 0, 0, 8'h00, 8'h00, 8'h03, 0)};
        tbl[17] = {3'b000, mk(0, 0, 0, 8'h00, 8'h00, 8'h03, 0)};
        tbl[18] = {3'b101, zero};
        tbl[19] = {3'b000, zero};
        tbl[20] = {3'b010, zero};
        tbl[21] = {3'b000, zero};
        tbl[22] = {3'b001, zero};
        tbl[23] = {3'b000, zero};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        compare("reset", zero);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 24; i++)
            stepx($sformatf("vec%0d", i), tbl[i].ss, tbl[i].lap, tbl[i].clr, tbl[i].exp);

        // 100 ticks from IDLE -> 00:01.00, EN100HZ every 4th cycle
        stepx("start", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        en_cnt = 0;
        en_bad = 0;
        for (int i = 1; i < 400; i++) begin
            step(0, 0, 0);
            if (EN100HZ === 1'b1) en_cnt++;
            if (EN100HZ !== ((i % 4) == 3)) en_bad++;
        end
        stepx("100ticks", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        chk_int("en_count", en_cnt, 100);
        chk_int("en_phase", en_bad, 0);

        // Pause with two prescaler counts banked, resume
        stepx("run_c1", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        stepx("pause_c2", 1, 0, 0, mk(0, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            if (EN100HZ !== 1'b0 || RUNNING !== 1'b0) en_cnt++;
        end
        chk_int("paused_quiet", en_cnt, 0);
        stepx("resume", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        stepx("resume+1", 0, 0, 0, mk(1, 0, 1, 8'h00, 8'h01, 8'h00, 0));
        stepx("resume+2", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h01, 8'h01, 0));

`ifdef SW_LAP_EN
        stepx("lap_pre_pause", 1, 0, 0, mk(0, 0, 0, 8'h00, 8'h01, 8'h01, 0));
        stepx("lap_pre_clr", 0, 0, 1, zero);
        stepx("lap_start", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        for (int i = 1; i < 148; i++) step(0, 0, 0);
        stepx("live37", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h37, 0));
        stepx("lap_in", 0, 1, 0, mk(1, 1, 0, 8'h00, 8'h00, 8'h37, 0));
        for (int i = 0; i < 19; i++) step(0, 0, 0);
        stepx("lap_held", 0, 0, 0, mk(1, 1, 0, 8'h00, 8'h00, 8'h37, 0));
        stepx("lap_out", 0, 1, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h42, 0));
        stepx("pre_tick", 0, 0, 0, mk(1, 0, 1, 8'h00, 8'h00, 8'h42, 0));
        stepx("lap_on_tick", 0, 1, 0, mk(1, 1, 0, 8'h00, 8'h00, 8'h42, 0));
        stepx("lap_tick_hold", 0, 0, 0, mk(1, 1, 0, 8'h00, 8'h00, 8'h42, 0));
        stepx("lap_tick_out", 0, 1, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h43, 0));
        stepx("pre_tick2", 0, 0, 0, mk(1, 0, 1, 8'h00, 8'h00, 8'h43, 0));
        stepx("lap_in2", 0, 1, 0, mk(1, 1, 0, 8'h00, 8'h00, 8'h43, 0));
        stepx("lap_pause", 1, 0, 0, mk(0, 1, 0, 8'h00, 8'h00, 8'h43, 0));
        stepx("lap_pause_hold", 0, 0, 0, mk(0, 1, 0, 8'h00, 8'h00, 8'h43, 0));
        stepx("lap_pause_clr", 0, 0, 1, zero);
        stepx("after_clr", 0, 0, 0, zero);
`else
        stepx("lap_ignored", 0, 1, 0, mk(1, 0, 0, 8'h00, 8'h01, 8'h01, 0));
        stepx("nolap_pause", 1, 0, 0, mk(0, 0, 0, 8'h00, 8'h01, 8'h01, 0));
        stepx("nolap_clr", 0, 0, 1, zero);
`endif

        // Wrap past 59:59.99 from a preloaded paused value
        stepx("wrap_start", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        stepx("wrap_c1", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        stepx("wrap_pause", 1, 0, 0, zero);
        drive(0, 0, 0);
        force dut.min_q = 8'h59;
        force dut.sec_q = 8'h59;
        force dut.cs_q  = 8'h99;
        exp_q.push_back(mk(0, 0, 0, 8'h59, 8'h59, 8'h99, 0));
        @(posedge CLK);
        #1;
        release dut.min_q;
        release dut.sec_q;
        release dut.cs_q;
        compare("preload", exp_q.pop_front());
        stepx("wrap_resume", 1, 0, 0, mk(1, 0, 0, 8'h59, 8'h59, 8'h99, 0));
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0, 0);
            if (EN100HZ === 1'b1) seen = 1'b1;
        end
        chk_int("wrap_tick_seen", int'(seen), 1);
        stepx("wrapped", 0, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1));
        stepx("ovf_pause", 1, 0, 0, mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1));
        stepx("ovf_clr", 0, 0, 1, zero);
        stepx("ovf_idle", 0, 0, 0, zero);

        // Reset mid-run, then a button held across reset release
        stepx("rst_start", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        BTN_SS = 1'b1;
        exp_q.push_back(zero);
        @(posedge CLK);
        #1;
        compare("rst_mid", exp_q.pop_front());
        @(negedge CLK);
        RST = 1'b0;
        stepx("held1", 1, 0, 0, zero);
        stepx("held2", 1, 0, 0, zero);
        stepx("released", 0, 0, 0, zero);
        stepx("repressed", 1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
